// File: rtl/bram_sdp_pkg.sv
// Shared sizing helpers and parameter-check macros for the SDP BRAM FIFO family.
`ifndef BRAM_SDP_PKG_SV
`define BRAM_SDP_PKG_SV

// Elaboration-time parameter guard; use inside a module body.
`define BRAM_SDP_PARAM_CHECK(blk, cond, msg) \
    if (!(cond)) begin : blk \
        $error(msg); \
    end

package bram_sdp_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

    function automatic int unsigned fifo_depth(input int unsigned awidth);
        return 32'(1) << awidth;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned awidth);
        return awidth + 1;
    endfunction

endpackage

`endif

// File: rtl/bram_sdp_core.sv
// Bare simple-dual-port memory: synchronous write, registered read; the BRAM inference target.
module bram_sdp_core #(
    parameter int unsigned DWIDTH = 36,
    parameter int unsigned AWIDTH = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 32'(1) << AWIDTH;

    (* no_rw_check *) logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Output register doubles as the BRAM read latch, so it carries no reset.
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/bram_sdp_fifo.sv
// Synchronous FIFO over one SDP BRAM: pointers, occupancy, watermark flags, sticky errors.
module bram_sdp_fifo
    import bram_sdp_pkg::*;
#(
    parameter int unsigned DWIDTH   = 36,
    parameter int unsigned AWIDTH   = 10,
    parameter int unsigned AF_LEVEL = (1 << AWIDTH) - 4,
    parameter int unsigned AE_LEVEL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned DEPTH = fifo_depth(AWIDTH);
    localparam int unsigned PW    = ptr_width(AWIDTH);

    `BRAM_SDP_PARAM_CHECK(g_chk_af, AF_LEVEL <= DEPTH, "AF_LEVEL exceeds FIFO depth")
    `BRAM_SDP_PARAM_CHECK(g_chk_ae, AE_LEVEL < DEPTH, "AE_LEVEL must be below FIFO depth")

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          rd_acc_c;
    logic          wr_acc_c;
    logic [PW-1:0] cnt_nxt_c;

    // Accept logic: a read frees a slot, so a full FIFO can still take a paired write.
    always_comb begin
        rd_acc_c  = rd_en & ~empty;
        wr_acc_c  = wr_en & (~full | rd_acc_c);
        cnt_nxt_c = count;
        if (wr_acc_c && !rd_acc_c)      cnt_nxt_c = count + PW'(1);
        else if (rd_acc_c && !wr_acc_c) cnt_nxt_c = count - PW'(1);
    end

    // Flags are registered from the next count so they move together with count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            rd_valid     <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc_c) wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc_c) rd_ptr <= rd_ptr + PW'(1);
            count        <= cnt_nxt_c;
            empty        <= (cnt_nxt_c == '0);
            full         <= (cnt_nxt_c == PW'(DEPTH));
            almost_empty <= (cnt_nxt_c <= PW'(AE_LEVEL));
            almost_full  <= (cnt_nxt_c >= PW'(AF_LEVEL));
            rd_valid     <= rd_acc_c;
            overflow     <= overflow | (wr_en & full & ~rd_acc_c);
            underflow    <= underflow | (rd_en & empty);
        end
    end

    bram_sdp_core #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_core (
        .clk     (clk),
        .wr_en   (wr_acc_c),
        .wr_addr (wr_ptr[AWIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_acc_c),
        .rd_addr (rd_ptr[AWIDTH-1:0]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_bram_sdp_fifo.sv
// Directed self-checking bench for bram_sdp_fifo in a 16-deep, 8-bit configuration.
module tb_bram_sdp_fifo;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    bram_sdp_fifo #(
        .DWIDTH   (DW),
        .AWIDTH   (AW),
        .AF_LEVEL (12),
        .AE_LEVEL (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        step();
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++;
        if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty: got %b want 1", almost_empty); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++;
        if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b want 0", almost_full); end
        checks++;
        if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        checks++;
        if ({overflow, underflow} !== 2'b00) begin
            errors++; $display("FAIL reset_sticky: got ovf=%b unf=%b want 0 0", overflow, underflow);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            wr_en   = 1'b1;
            wr_data = DW'(i);
            step();
            checks++;
            if (count !== 5'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i); end
            checks++;
            if (full !== (i == 16)) begin errors++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, i == 16); end
            checks++;
            if (almost_full !== (i >= 12)) begin
                errors++; $display("FAIL fill_afull[%0d]: got %b want %b", i, almost_full, i >= 12);
            end
            checks++;
            if (almost_empty !== (i <= 4)) begin
                errors++; $display("FAIL fill_aempty[%0d]: got %b want %b", i, almost_empty, i <= 4);
            end
            checks++;
            if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d]: got %b want 0", i, empty); end
        end
        wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b want 1", overflow); end
        checks++;
        if (count !== 5'd16) begin errors++; $display("FAIL overflow_count: got %0d want 16", count); end
    endtask

    task automatic test_full_rdwr();
        for (int k = 0; k < 4; k++) begin
            wr_en   = 1'b1;
            rd_en   = 1'b1;
            wr_data = DW'(8'hA0 + k);
            step();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== DW'(k + 1)) begin
                errors++;
                $display("FAIL full_rdwr_data[%0d]: got v=%b d=%h want v=1 d=%h", k, rd_valid, rd_data, k + 1);
            end
            checks++;
            if (count !== 5'd16 || full !== 1'b1) begin
                errors++; $display("FAIL full_rdwr_level[%0d]: got cnt=%0d full=%b want 16 1", k, count, full);
            end
            checks++;
            if (overflow !== 1'b1) begin errors++; $display("FAIL full_rdwr_ovf[%0d]: got %b want 1", k, overflow); end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_drain();
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] e;
        for (int i = 5; i <= 16; i++) exp_q.push_back(DW'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(DW'(8'hA0 + i));
        for (int i = 0; i < 16; i++) begin
            e     = exp_q.pop_front();
            rd_en = 1'b1;
            step();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                errors++; $display("FAIL drain_data[%0d]: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, e);
            end
            checks++;
            if (count !== 5'(15 - i)) begin
                errors++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, 15 - i);
            end
        end
        checks++;
        if (empty !== 1'b1 || underflow !== 1'b0) begin
            errors++; $display("FAIL drain_end: got empty=%b unf=%b want 1 0", empty, underflow);
        end
        step();
        rd_en = 1'b0;
        checks++;
        if (underflow !== 1'b1 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL underflow_set: got unf=%b v=%b want 1 0", underflow, rd_valid);
        end
    endtask

    task automatic test_rdwr_empty();
        do_reset();
        step();
        rd_en   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h55;
        step();
        checks++;
        if (underflow !== 1'b1 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL rdwr_empty_reject: got unf=%b v=%b want 1 0", underflow, rd_valid);
        end
        checks++;
        if (count !== 5'd1 || empty !== 1'b0) begin
            errors++; $display("FAIL rdwr_empty_count: got cnt=%0d empty=%b want 1 0", count, empty);
        end
        wr_en = 1'b0;
        step();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h55) begin
            errors++; $display("FAIL rdwr_empty_data: got v=%b d=%h want v=1 d=55", rd_valid, rd_data);
        end
        checks++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL rdwr_empty_after: got cnt=%0d empty=%b want 0 1", count, empty);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] prev;
        do_reset();
        step();
        prev = '0;
        for (int i = 0; i < 40; i++) begin
            wr_en   = 1'b1;
            rd_en   = (i > 0);
            wr_data = DW'(i * 7 + 3);
            step();
            checks++;
            if (count !== 5'd1) begin errors++; $display("FAIL wrap_count[%0d]: got %0d want 1", i, count); end
            if (i > 0) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== prev) begin
                    errors++; $display("FAIL wrap_data[%0d]: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, prev);
                end
            end
            prev = DW'(i * 7 + 3);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL wrap_sticky: got ovf=%b unf=%b want 0 0", overflow, underflow);
        end
    endtask

    task automatic test_async_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = DW'(8'hC0 + i);
            step();
        end
        wr_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL async_reset: got cnt=%0d empty=%b want 0 1", count, empty);
        end
        checks++;
        if (almost_empty !== 1'b1 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset_flags: got ae=%b v=%b want 1 0", almost_empty, rd_valid);
        end
        step();
        rst_n   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h99;
        step();
        wr_en = 1'b0;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h99 || count !== 5'd0) begin
            errors++;
            $display("FAIL post_reset_rw: got v=%b d=%h cnt=%0d want v=1 d=99 cnt=0", rd_valid, rd_data, count);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        test_reset();
        test_fill();
        test_full_rdwr();
        test_drain();
        test_rdwr_empty();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
